// File: rtl/cap_touch_pkg.sv
// Shared types and defaults for the capacitive touch scanner.
package cap_touch_pkg;

    localparam int unsigned DEF_CNT_W   = 12;
    localparam int unsigned DEF_TIMEOUT = 4095;

    typedef logic [DEF_CNT_W-1:0] count_t;

    // Scanner FSM encoding
    typedef logic [1:0] state_t;
    localparam state_t IDLE      = 2'd0;
    localparam state_t DISCHARGE = 2'd1;
    localparam state_t MEASURE   = 2'd2;
    localparam state_t EVAL      = 2'd3;

endpackage

// File: rtl/cap_touch_sync.sv
// Two-flop synchronizer for the raw pad levels. Resets high so an idle pad
// never looks like it is still charging.
module cap_touch_sync #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Metastability stage followed by the stable output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cap_touch_scanner.sv
// Round-robin capacitive touch scanner: discharge a pad, release it, count
// cycles until it charges high, compare against a calibrated baseline.
// Optional macro CAP_TOUCH_DEBOUNCE_EN: touched bits only change when two
// consecutive comparison sweeps agree.
module cap_touch_scanner
    import cap_touch_pkg::*;
#(
    parameter int unsigned NUM_CH           = 8,
    parameter int unsigned CNT_W            = DEF_CNT_W,
    parameter int unsigned DISCHARGE_CYCLES = 16,
    parameter int unsigned TIMEOUT          = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              recal,
    input  logic [7:0]        thresh,
    input  logic [NUM_CH-1:0] pad_in,
    output logic [NUM_CH-1:0] pad_out,
    output logic [NUM_CH-1:0] pad_oe,
    output logic [NUM_CH-1:0] touched,
    output logic              scan_done,
    output logic [2:0]        cur_ch,
    output logic [CNT_W-1:0]  last_count,
    output logic              timeout_flag
);

    localparam int unsigned    TIM_W    = $clog2(DISCHARGE_CYCLES + 1);
    localparam logic [TIM_W-1:0] TIM_LAST = TIM_W'(DISCHARGE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [2:0]       LAST_CH  = 3'(NUM_CH - 1);

    state_t            state;
    state_t            state_next;
    logic [TIM_W-1:0]  timer;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  baseline [NUM_CH];
    logic              cal_pending;
    logic              recal_seen;
    logic [2:0]        ch_next;
    logic [NUM_CH-1:0] pad_sync;
    logic              pad_cur;
    logic [CNT_W:0]    limit;
    logic              raw_touch;
    logic              sweep_end;
`ifdef CAP_TOUCH_DEBOUNCE_EN
    logic [NUM_CH-1:0] hist;
`endif

    cap_touch_sync #(
        .WIDTH (NUM_CH)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pad_in),
        .q     (pad_sync)
    );

    // Pads are only ever pulled low; the enable does the switching
    assign pad_out   = '0;
    assign pad_cur   = pad_sync[cur_ch];
    // One extra bit so baseline + thresh can never wrap
    assign limit     = {1'b0, baseline[cur_ch]} + (CNT_W+1)'(thresh);
    assign raw_touch = ({1'b0, count} > limit);
    assign sweep_end = (state == EVAL) && (cur_ch == LAST_CH);
    assign ch_next   = (state != EVAL) ? cur_ch :
                       (cur_ch == LAST_CH) ? 3'd0 : cur_ch + 3'd1;

    // Next-state decode; ena low aborts the channel in progress
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (ena) state_next = DISCHARGE;
            DISCHARGE: begin
                if (!ena)                   state_next = IDLE;
                else if (timer == TIM_LAST) state_next = MEASURE;
            end
            MEASURE: begin
                if (!ena)                             state_next = IDLE;
                else if (pad_cur || count == CNT_MAX) state_next = EVAL;
            end
            EVAL:      state_next = ena ? DISCHARGE : IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Sequencing, measurement, calibration and touch decision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            timer        <= '0;
            count        <= '0;
            pad_oe       <= '0;
            touched      <= '0;
            scan_done    <= 1'b0;
            cur_ch       <= 3'd0;
            last_count   <= '0;
            timeout_flag <= 1'b0;
            cal_pending  <= 1'b1;
            recal_seen   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) baseline[i] <= '0;
`ifdef CAP_TOUCH_DEBOUNCE_EN
            hist         <= '0;
`endif
        end else begin
            state     <= state_next;
            scan_done <= 1'b0;
            // Registered so the pad drivers never see decode glitches
            pad_oe    <= (state_next == DISCHARGE) ? (NUM_CH'(1) << ch_next) : '0;
            timer     <= (state == DISCHARGE) ? timer + TIM_W'(1) : '0;

            if (state == DISCHARGE) begin
                count <= '0;
            end else if (state == MEASURE && state_next == MEASURE) begin
                count <= count + CNT_W'(1);
            end

            if (state == EVAL) begin
                last_count   <= count;
                timeout_flag <= (count == CNT_MAX);
                cur_ch       <= ch_next;
                if (cal_pending) begin
                    baseline[cur_ch] <= count;
                    touched[cur_ch]  <= 1'b0;
`ifdef CAP_TOUCH_DEBOUNCE_EN
                    hist[cur_ch]     <= 1'b0;
`endif
                end else begin
`ifdef CAP_TOUCH_DEBOUNCE_EN
                    hist[cur_ch] <= raw_touch;
                    if (raw_touch == hist[cur_ch]) touched[cur_ch] <= raw_touch;
`else
                    touched[cur_ch] <= raw_touch;
`endif
                end
                if (cur_ch == LAST_CH) begin
                    scan_done   <= 1'b1;
                    cal_pending <= recal_seen | recal;
                    recal_seen  <= 1'b0;
                end
            end

            // Hold a mid-sweep recal until the sweep boundary
            if (recal && !sweep_end) recal_seen <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cap_touch_scanner.sv
// Self-checking bench for cap_touch_scanner: an emulated RC pad per channel,
// a sweep-level reference model, a vector table and a few timed sequences.
module tb_cap_touch_scanner;

    localparam int NUM_CH  = 8;
    localparam int CNT_W   = 12;
    localparam int DIS     = 16;
    localparam int TIMEOUT = 4095;
    localparam int NEVER   = 100000;
    localparam int LIMIT   = 6000;

    logic              clk    = 1'b0;
    logic              rst_n  = 1'b0;
    logic              ena    = 1'b0;
    logic              recal  = 1'b0;
    logic [7:0]        thresh = 8'd0;
    logic [NUM_CH-1:0] pad_in = '1;
    logic [NUM_CH-1:0] pad_out;
    logic [NUM_CH-1:0] pad_oe;
    logic [NUM_CH-1:0] touched;
    logic              scan_done;
    logic [2:0]        cur_ch;
    logic [CNT_W-1:0]  last_count;
    logic              timeout_flag;

    always #5 clk = ~clk;

    cap_touch_scanner dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .recal        (recal),
        .thresh       (thresh),
        .pad_in       (pad_in),
        .pad_out      (pad_out),
        .pad_oe       (pad_oe),
        .touched      (touched),
        .scan_done    (scan_done),
        .cur_ch       (cur_ch),
        .last_count   (last_count),
        .timeout_flag (timeout_flag)
    );

    int n_vec = 0;
    int n_err = 0;

    // Raw pad low time (cycles) after release; the synchronizer adds two more
    int rise     [NUM_CH];
    int low_left [NUM_CH];

    // Reference model state
    int                base_m [NUM_CH];
    bit                cal_m    = 1'b1;
    bit                recal_m  = 1'b0;
    logic [NUM_CH-1:0] touched_m = '0;
    logic [NUM_CH-1:0] hist_m    = '0;

    typedef struct {
        int         base;
        int         c1;
        int         n1;
        int         c2;
        int         n2;
        logic [7:0] thr;
        int         recal_after;
        logic [7:0] exp_t;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp_v, exp_v);
        end
    endtask

    // RC pad: held low while driven, then stays low for rise[c] cycles
    initial begin
        for (int c = 0; c < NUM_CH; c++) begin
            low_left[c] = 0;
            rise[c]     = 38;
        end
        forever begin
            @(negedge clk);
            for (int c = 0; c < NUM_CH; c++) begin
                if (pad_oe[c]) begin
                    pad_in[c]   = 1'b0;
                    low_left[c] = rise[c];
                end else if (low_left[c] > 0) begin
                    low_left[c]--;
                    pad_in[c] = 1'b0;
                end else begin
                    pad_in[c] = 1'b1;
                end
            end
        end
    end

    function automatic int to_rise(input int c);
        return (c == NEVER) ? NEVER : c - 2;
    endfunction

    // Measured count = raw low time + 2 synchronizer cycles, saturating
    function automatic int exp_count(input int r);
        return (r + 2 > TIMEOUT) ? TIMEOUT : r + 2;
    endfunction

    task automatic model_eval(input int ch, output int cnt);
        bit raw;
        cnt = exp_count(rise[ch]);
        if (cal_m) begin
            base_m[ch]    = cnt;
            touched_m[ch] = 1'b0;
            hist_m[ch]    = 1'b0;
        end else begin
            raw = (cnt > base_m[ch] + int'(thresh));
`ifdef CAP_TOUCH_DEBOUNCE_EN
            if (raw == hist_m[ch]) touched_m[ch] = raw;
            hist_m[ch] = raw;
`else
            touched_m[ch] = raw;
`endif
        end
        if (ch == NUM_CH - 1) begin
            cal_m   = recal_m;
            recal_m = 1'b0;
        end
    endtask

    task automatic wait_channel(input int ch);
        int n = 0;
        int cnt;
        while (cur_ch == 3'(ch) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) begin
            n_vec++;
            n_err++;
            $display("FAIL ch%0d_done: channel never completed, cur_ch=%0d expected change", ch, cur_ch);
            return;
        end
        model_eval(ch, cnt);
        check($sformatf("ch%0d_last_count", ch), 32'(last_count), 32'(cnt));
        check($sformatf("ch%0d_timeout_flag", ch), 32'(timeout_flag), 32'(cnt == TIMEOUT));
        check($sformatf("ch%0d_touched", ch), 32'(touched), 32'(touched_m));
        check($sformatf("ch%0d_scan_done", ch), 32'(scan_done), 32'(ch == NUM_CH - 1));
        check($sformatf("ch%0d_next_ch", ch), 32'(cur_ch), 32'((ch + 1) % NUM_CH));
    endtask

    task automatic wait_oe(input logic [NUM_CH-1:0] val, input string name);
        int n = 0;
        while (pad_oe !== val && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: pad_oe=0x%0h never reached 0x%0h", name, pad_oe, val);
        end
    endtask

    task automatic pulse_recal();
        recal   = 1'b1;
        recal_m = 1'b1;
        @(negedge clk);
        recal = 1'b0;
    endtask

    task automatic run_sweep(input int recal_after);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            wait_channel(ch);
            if (ch == recal_after) pulse_recal();
        end
        @(negedge clk);
        check("scan_done_one_cycle", 32'(scan_done), 32'(0));
    endtask

    task automatic set_all(input int cnt);
        for (int c = 0; c < NUM_CH; c++) rise[c] = to_rise(cnt);
    endtask

    // Hard stop in case a bounded wait is itself never reached
    initial begin
        #800000;
        $display("FAIL watchdog: simulation ran past its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c7;

        tbl[0] = '{40, -1,  0, -1,  0, 8'd10, -1, 8'h00};
        tbl[1] = '{40, -1,  0, -1,  0, 8'd10, -1, 8'h00};
        tbl[2] = '{40,  3, 60, -1,  0, 8'd10, -1, 8'h08};
        tbl[3] = '{40,  3, 50, -1,  0, 8'd10, -1, 8'h00};
        tbl[4] = '{40,  5, NEVER, -1, 0, 8'd10, -1, 8'h20};
        tbl[5] = '{40,  1, 55,  6, 51, 8'd10, -1, 8'h42};
        tbl[6] = '{40,  0, 41,  7, 40, 8'd0,  -1, 8'h01};
        tbl[7] = '{40,  2, 70, -1,  0, 8'd10,  3, 8'h04};
        tbl[8] = '{70, -1,  0, -1,  0, 8'd10, -1, 8'h00};
        tbl[9] = '{70,  4, 81,  0, 75, 8'd10, -1, 8'h10};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_touched", 32'(touched), 32'(0));
        check("rst_pad_oe", 32'(pad_oe), 32'(0));
        check("rst_pad_out", 32'(pad_out), 32'(0));
        check("rst_scan_done", 32'(scan_done), 32'(0));
        check("rst_cur_ch", 32'(cur_ch), 32'(0));
        check("rst_last_count", 32'(last_count), 32'(0));
        check("rst_timeout_flag", 32'(timeout_flag), 32'(0));
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_pad_oe", 32'(pad_oe), 32'(0));

        // Table-driven sweeps
        for (int v = 0; v < 10; v++) begin
            set_all(tbl[v].base);
            if (tbl[v].c1 >= 0) rise[tbl[v].c1] = to_rise(tbl[v].n1);
            if (tbl[v].c2 >= 0) rise[tbl[v].c2] = to_rise(tbl[v].n2);
            thresh = tbl[v].thr;
            ena    = 1'b1;
            run_sweep(tbl[v].recal_after);
`ifndef CAP_TOUCH_DEBOUNCE_EN
            check($sformatf("tbl%0d_touched", v), 32'(touched), 32'(tbl[v].exp_t));
`endif
        end

        // ena dropped mid-MEASURE of channel 2, then restarted
        set_all(70);
        thresh = 8'd10;
        wait_channel(0);
        wait_channel(1);
        wait_oe(8'h04, "ena_ch2_discharge");
        wait_oe(8'h00, "ena_ch2_measure");
        repeat (5) @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        check("abort_pad_oe", 32'(pad_oe), 32'(0));
        check("abort_cur_ch", 32'(cur_ch), 32'(2));
        check("abort_touched", 32'(touched), 32'(touched_m));
        repeat (10) @(negedge clk);
        check("idle_hold_cur_ch", 32'(cur_ch), 32'(2));
        check("idle_hold_pad_oe", 32'(pad_oe), 32'(0));
        check("idle_hold_last_count", 32'(last_count), 32'(70));
        ena = 1'b1;
        wait_oe(8'h04, "restart_ch2");
        n = 0;
        while (pad_oe == 8'h04 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("restart_discharge_len", 32'(n), 32'(DIS));
        for (int ch = 2; ch < NUM_CH; ch++) wait_channel(ch);
        @(negedge clk);

        // recal landing exactly on the sweep-ending EVAL edge
        for (int ch = 0; ch < NUM_CH - 1; ch++) wait_channel(ch);
        c7 = exp_count(rise[7]);
        wait_oe(8'h80, "end_ch7_discharge");
        wait_oe(8'h00, "end_ch7_measure");
        repeat (c7 + 1) @(negedge clk);
        recal   = 1'b1;
        recal_m = 1'b1;
        @(negedge clk);
        recal = 1'b0;
        wait_channel(7);
        set_all(50);
        run_sweep(-1);
        check("recal_end_cal_touched", 32'(touched), 32'(0));
        rise[6] = to_rise(61);
        run_sweep(-1);
`ifndef CAP_TOUCH_DEBOUNCE_EN
        check("recal_end_new_base", 32'(touched), 32'(8'h40));
`endif

        // Randomized sweeps against the model
        for (int s = 0; s < 6; s++) begin
            for (int c = 0; c < NUM_CH; c++) rise[c] = to_rise(int'($urandom_range(100, 20)));
            thresh = 8'($urandom_range(40, 0));
            run_sweep(($urandom_range(2, 0) == 0) ? int'($urandom_range(6, 0)) : -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
